multireceive: RTL

- Receive-side counterpart of the number sender link.
- Decodes a frame of six 3-bit symbols arriving on a parallel data bus (in0..in2) qualified by a control strobe (controlIn).
- Reassembles the symbols, most significant digit first, into a 32-bit decimal value.
- Sits on the far board's input pins and hands the decoded number to downstream logic with a done flag.

---
 rtl/multireceive_if.sv | 25 ++
 rtl/multireceive.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/multireceive_if.sv
// Pin-level bundle between the number sender link and its receiver.
`timescale 1ns/1ps
interface multireceive_if;
  logic        enabled;
  logic        in0;
  logic        in1;
  logic        in2;
  logic        controlIn;
  logic [31:0] num;
  logic        done;
  logic        timeout_err;
  logic [2:0]  count;

  // Sender / stimulus side
  modport master (
    output enabled, in0, in1, in2, controlIn,
    input  num, done, timeout_err, count
  );

  // Receiver side
  modport slave (
    input  enabled, in0, in1, in2, controlIn,
    output num, done, timeout_err, count
  );
endinterface

// File: rtl/multireceive.sv
// Receiver for the number sender link: qualifies a slow strobe, collects DIGITS 3-bit
// symbols MSD first and presents the decimal value with a done / timeout status.
`timescale 1ns/1ps
module multireceive #(
  parameter int unsigned MIN_HIGH = 1000,     // must be >= 2
  parameter int unsigned TIMEOUT  = 24000000,
  parameter int unsigned DIGITS   = 6
) (
  input logic           hwclk,
  input logic           rst_n,
  multireceive_if.slave bus
);
  localparam int unsigned     HlW       = $clog2(MIN_HIGH + 1);
  localparam int unsigned     GapW      = $clog2(TIMEOUT + 1);
  localparam logic [HlW-1:0]  HlLast    = HlW'(MIN_HIGH - 1);
  localparam logic [GapW-1:0] GapLast   = GapW'(TIMEOUT - 1);
  localparam logic [2:0]      CountFull = 3'(DIGITS);

  typedef enum logic [2:0] {
    StIdle, StArm, StWaitHigh, StQualify, StWaitLow, StDone, StError
  } state_e;

  state_e          state_q;
  logic [3:0]      sync1_q, sync2_q;  // {controlIn, in2, in1, in0}
  logic [HlW-1:0]  hl_q;              // shared high/low run-length counter
  logic [GapW-1:0] gap_q;
  logic [31:0]     acc_q, num_q, acc_next;
  logic [2:0]      count_q;
  logic            done_q, err_q;

  logic       strobe;
  logic [2:0] sym;
  logic       hl_full, gap_run, capture, expire;

  assign strobe   = sync2_q[3];
  assign sym      = sync2_q[2:0];
  // hl_q counts samples already seen, so this sample completes the run of MIN_HIGH
  assign hl_full  = (hl_q == HlLast);
  assign capture  = (state_q == StQualify) && strobe && hl_full;
  assign gap_run  = (state_q inside {StWaitHigh, StQualify, StWaitLow}) && (count_q != 3'd0);
  // A capture in the expiry cycle wins over the timeout
  assign expire   = gap_run && (gap_q == GapLast) && !capture;
  assign acc_next = (acc_q << 3) + (acc_q << 1) + {29'd0, sym};

  assign bus.num         = num_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = err_q;
  assign bus.count       = count_q;

  // Two-flop synchronizers for the asynchronous link pins
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.controlIn, bus.in2, bus.in1, bus.in0};
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM with registered status outputs, gap timer and accumulator
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hl_q    <= '0;
      gap_q   <= '0;
      acc_q   <= '0;
      num_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (!bus.enabled) begin
      // num deliberately survives a disable
      state_q <= StIdle;
      hl_q    <= '0;
      gap_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (expire) begin
      state_q <= StError;
      err_q   <= 1'b1;
      acc_q   <= '0;
      gap_q   <= '0;
      hl_q    <= '0;
    end else begin
      if (capture) begin
        gap_q <= '0;
      end else if (gap_run) begin
        gap_q <= gap_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          hl_q    <= '0;
          state_q <= StArm;
        end
        // Reject a strobe that is already high when the receiver is enabled
        StArm: begin
          if (strobe) begin
            hl_q <= '0;
          end else if (hl_full) begin
            hl_q    <= '0;
            state_q <= StWaitHigh;
          end else begin
            hl_q <= hl_q + 1'b1;
          end
        end
        StWaitHigh: begin
          if (strobe) begin
            hl_q    <= HlW'(1);
            state_q <= StQualify;
          end
        end
        StQualify: begin
          if (!strobe) begin
            hl_q    <= '0;
            state_q <= StWaitHigh;
          end else if (hl_full) begin
            acc_q   <= acc_next;
            count_q <= count_q + 3'd1;
            hl_q    <= '0;
            state_q <= StWaitLow;
          end else begin
            hl_q <= hl_q + 1'b1;
          end
        end
        StWaitLow: begin
          if (strobe) begin
            hl_q <= '0;
          end else if (hl_full) begin
            hl_q    <= '0;
            state_q <= (count_q == CountFull) ? StDone : StWaitHigh;
          end else begin
            hl_q <= hl_q + 1'b1;
          end
        end
        StDone: begin
          num_q  <= acc_q;
          done_q <= 1'b1;
        end
        StError: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule
